// File: rtl/reg_file_if.sv
// Register file access bundle: two read ports and one write port.
// Master drives addresses/write data; slave returns the read data.
interface reg_file_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              we;
  logic [DATA_W-1:0] read_a;
  logic [DATA_W-1:0] read_b;

  modport master (
    output ra, rb, wa, wd, we,
    input  read_a, read_b
  );

  modport slave (
    input  ra, rb, wa, wd, we,
    output read_a, read_b
  );
endinterface

// File: rtl/reg_file.sv
// ProtoCore GPR file: 2 combinational read ports, 1 write port (lands on the clock edge).
// No backpressure; every write with we=1 is accepted on the edge, and there is no write-through.
module reg_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.we) begin
      regs[bus.wa] <= bus.wd;
    end
  end

  // Reads see the stored value only; a same-cycle write shows up after the edge.
  assign bus.read_a = regs[bus.ra];
  assign bus.read_b = regs[bus.rb];
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// compared against an array model of the 16 registers.
module tb_reg_file;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [DATA_W-1:0] model [DEPTH];

  reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic drive(input logic w, input int waddr, input logic [7:0] wdat,
                       input int a, input int b);
    bus.we = w;
    bus.wa = ADDR_W'(waddr);
    bus.wd = wdat;
    bus.ra = ADDR_W'(a);
    bus.rb = ADDR_W'(b);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 4, 8'h99, 0, 0);
    repeat (2) @(posedge clk);
    model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      drive(1'b1, i, 8'hFF, i, DEPTH - 1 - i);
      #1;
      n_tests++;
      if (bus.read_a !== 8'h00 || bus.read_b !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_sweep addr=%0d read_a=%h read_b=%h exp=00", i, bus.read_a, bus.read_b);
      end
    end
    @(negedge clk);
    bus.we = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_fill();
    // First write lands on the first edge after reset release.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, i, 8'(i * 8'h11), 0, 0);
      @(posedge clk);
      model[i] = 8'(i * 8'h11);
      @(negedge clk);
    end
    bus.we = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.ra = ADDR_W'(i);
      bus.rb = ADDR_W'(DEPTH - 1 - i);
      #1;
      n_tests++;
      if (bus.read_a !== 8'(i * 8'h11) || bus.read_b !== 8'((15 - i) * 8'h11)) begin
        n_fail++;
        $display("FAIL fill addr=%0d read_a=%h exp=%h read_b=%h exp=%h", i,
                 bus.read_a, 8'(i * 8'h11), bus.read_b, 8'((15 - i) * 8'h11));
      end
    end
  endtask

  task automatic test_overwrite();
    @(negedge clk);
    drive(1'b1, 3, 8'hAA, 0, 0);
    @(posedge clk);
    model[3] = 8'hAA;
    @(negedge clk);
    drive(1'b0, 0, 8'h00, 3, 3);
    #1;
    n_tests++;
    if (bus.read_a !== 8'hAA || bus.read_b !== 8'hAA) begin
      n_fail++;
      $display("FAIL overwrite read_a=%h read_b=%h exp=aa", bus.read_a, bus.read_b);
    end
    bus.ra = 4'd12;
    #1;
    n_tests++;
    if (bus.read_a !== 8'hCC) begin
      n_fail++;
      $display("FAIL overwrite_neighbor read_a=%h exp=cc", bus.read_a);
    end
  endtask

  task automatic test_we_off();
    @(negedge clk);
    drive(1'b0, 5, 8'h11, 5, 5);
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.read_a !== 8'h55) begin
      n_fail++;
      $display("FAIL we_off read_a=%h exp=55", bus.read_a);
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    drive(1'b1, 7, 8'h3C, 7, 7);
    #1;
    n_tests++;
    if (bus.read_a !== 8'h77) begin
      n_fail++;
      $display("FAIL collision_before read_a=%h exp=77", bus.read_a);
    end
    @(posedge clk);
    model[7] = 8'h3C;
    #1;
    bus.we = 1'b0;
    n_tests++;
    if (bus.read_a !== 8'h3C || bus.read_b !== 8'h3C) begin
      n_fail++;
      $display("FAIL collision_after read_a=%h read_b=%h exp=3c", bus.read_a, bus.read_b);
    end
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      int a, b, w;
      logic [7:0] d;
      logic e;
      @(negedge clk);
      a = $urandom_range(0, DEPTH - 1);
      b = $urandom_range(0, DEPTH - 1);
      w = $urandom_range(0, DEPTH - 1);
      d = 8'($urandom);
      e = 1'($urandom_range(0, 1));
      if ((c % 8) == 0) a = w;
      drive(e, w, d, a, b);
      #1;
      n_tests++;
      if (bus.read_a !== model[a] || bus.read_b !== model[b]) begin
        n_fail++;
        $display("FAIL random cyc=%0d ra=%0d read_a=%h exp=%h rb=%0d read_b=%h exp=%h",
                 c, a, bus.read_a, model[a], b, bus.read_b, model[b]);
      end
      @(posedge clk);
      if (e) model[w] = d;
    end
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    n_tests++;
    if (bus.read_a !== 8'h00 || bus.read_b !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset_immediate read_a=%h read_b=%h exp=00", bus.read_a, bus.read_b);
    end
    drive(1'b1, 9, 8'h5A, 9, 9);
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.read_a !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset_write_blocked read_a=%h exp=00", bus.read_a);
    end
    bus.we = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.ra = ADDR_W'(i);
      bus.rb = ADDR_W'(DEPTH - 1 - i);
      #1;
      n_tests++;
      if (bus.read_a !== model[i] || bus.read_b !== model[DEPTH - 1 - i]) begin
        n_fail++;
        $display("FAIL async_reset_sweep addr=%0d read_a=%h read_b=%h exp=00", i, bus.read_a, bus.read_b);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive(1'b1, 9, 8'hC3, 9, 0);
    @(posedge clk);
    model[9] = 8'hC3;
    #1;
    bus.we = 1'b0;
    n_tests++;
    if (bus.read_a !== 8'hC3 || bus.read_b !== 8'h00) begin
      n_fail++;
      $display("FAIL post_reset_write read_a=%h exp=c3 read_b=%h exp=00", bus.read_a, bus.read_b);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive(1'b0, 0, 8'h00, 0, 0);
    model_clear();
    #3;
    test_reset();
    test_fill();
    test_overwrite();
    test_we_off();
    test_collision();
    test_random(300);
    test_async_reset();
    test_random(200);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
